// File: rtl/prog_ram_loader_if.sv
// Bundle of the CPU memory port and the program-load stream.
// The master drives CPU requests and load words; the slave is the RAM/loader.
interface prog_ram_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    // CPU port
    logic              we;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    // Load sequencer port
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              busy;
    logic              load_done;
    logic [ADDR_W:0]   load_count;

    modport master (
        output we, address, data_in, load_start, load_valid, load_data, load_last,
        input  data_out, rd_valid, load_ready, busy, load_done, load_count
    );

    modport slave (
        input  we, address, data_in, load_start, load_valid, load_data, load_last,
        output data_out, rd_valid, load_ready, busy, load_done, load_count
    );
endinterface

// File: rtl/prog_ram_loader.sv
// Single-port program/data RAM with a clear-then-load sequencer.
// IDLE serves the CPU; CLEAR wipes every entry; LOAD streams an image from address 0.
module prog_ram_loader #(
    parameter int                 DATA_W    = 8,
    parameter int                 ADDR_W    = 5,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic               clock,
    input  logic               resetn,
    prog_ram_loader_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;          // clear pointer, then load pointer
    logic [ADDR_W:0]   count_q, count_d;      // wide enough to hold DEPTH
    logic              rdv_q, rdv_d;
    logic              done_q, done_d;
    logic              dout_zero_q, dout_zero_d; // data_out reads 0 until the first read

    // Single memory port: one write or one read per cycle
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem [DEPTH];

    // Next-state and memory-port control for the sequencer and CPU port
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        rdv_d       = 1'b0;
        done_d      = 1'b0;
        dout_zero_d = dout_zero_q;
        mem_we      = 1'b0;
        mem_addr    = bus.address;
        mem_wdata   = bus.data_in;
        rd_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A CPU write on the start edge still lands; the sweep overwrites it.
                mem_we = bus.we;
                if (bus.load_start) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                    count_d = '0;
                end else if (!bus.we) begin
                    rd_en       = 1'b1;
                    rdv_d       = 1'b1;
                    dout_zero_d = 1'b0;
                end
            end
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = ptr_q;
                mem_wdata = CLEAR_VAL;
                ptr_d     = ptr_q + 1'b1;   // wraps to 0, ready for LOAD
                if (ptr_q == '1) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.load_valid) begin
                    mem_we    = 1'b1;
                    mem_addr  = ptr_q;
                    mem_wdata = bus.load_data;
                    ptr_d     = ptr_q + 1'b1;
                    count_d   = count_q + 1'b1;
                    if (bus.load_last || ptr_q == '1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            rdv_q       <= 1'b0;
            done_q      <= 1'b0;
            dout_zero_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            rdv_q       <= rdv_d;
            done_q      <= done_d;
            dout_zero_q <= dout_zero_d;
        end
    end

    // RAM array with registered read; contents are deliberately not reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (rd_en) begin
            rd_data_q <= mem[bus.address];
        end
    end

    assign bus.data_out   = dout_zero_q ? '0 : rd_data_q;
    assign bus.rd_valid   = rdv_q;
    assign bus.load_ready = (state_q == S_LOAD);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.load_done  = done_q;
    assign bus.load_count = count_q;
endmodule
